// File: rtl/taus_pkg.sv
// rtl/taus_pkg.sv - shared constants, state type and seed check for the Tausworthe URNG
package taus_pkg;

  // Low bits cleared before each component's feedback shift.
  localparam logic [31:0] MASK0 = 32'hFFFF_FFFE;
  localparam logic [31:0] MASK1 = 32'hFFFF_FFF8;
  localparam logic [31:0] MASK2 = 32'hFFFF_FFF0;

  // Per-component shifts: (a) pre-xor left, (b) feedback right, (c) masked left.
  localparam int SH0A = 13;
  localparam int SH0B = 19;
  localparam int SH0C = 12;
  localparam int SH1A = 2;
  localparam int SH1B = 25;
  localparam int SH1C = 4;
  localparam int SH2A = 3;
  localparam int SH2B = 11;
  localparam int SH2C = 17;

  // Smaller seeds collapse a component into a degenerate all-zero cycle.
  localparam logic [31:0] SEED1_MIN = 32'd2;
  localparam logic [31:0] SEED2_MIN = 32'd8;
  localparam logic [31:0] SEED3_MIN = 32'd16;

  typedef enum logic [1:0] {
    UNSEEDED,
    WARM,
    RUN
  } state_e;

  function automatic logic seeds_legal(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    return (a >= SEED1_MIN) && (b >= SEED2_MIN) && (c >= SEED3_MIN);
  endfunction

endpackage

// File: rtl/taus_core.sv
// rtl/taus_core.sv - three-component 32-bit Tausworthe state with load and step
module taus_core
  import taus_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [31:0] seed1_i,
  input  logic [31:0] seed2_i,
  input  logic [31:0] seed3_i,
  output logic [31:0] s0_o,
  output logic [31:0] s1_o,
  output logic [31:0] s2_o,
  output logic [31:0] out_next_o
);

  logic [31:0] s0_q, s1_q, s2_q;
  logic [31:0] s0_d, s1_d, s2_d;
  logic [31:0] n0, n1, n2;

  // One generator step from the current state; the output is what a step would produce.
  always_comb begin
    n0 = ((s0_q & MASK0) << SH0C) ^ (((s0_q << SH0A) ^ s0_q) >> SH0B);
    n1 = ((s1_q & MASK1) << SH1C) ^ (((s1_q << SH1A) ^ s1_q) >> SH1B);
    n2 = ((s2_q & MASK2) << SH2C) ^ (((s2_q << SH2A) ^ s2_q) >> SH2B);
    out_next_o = n0 ^ n1 ^ n2;
  end

  // Seed load wins over a step; otherwise the state holds.
  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (load_i) begin
      s0_d = seed1_i;
      s1_d = seed2_i;
      s2_d = seed3_i;
    end else if (adv_i) begin
      s0_d = n0;
      s1_d = n1;
      s2_d = n2;
    end
  end

  // Component state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s0_o = s0_q;
  assign s1_o = s1_q;
  assign s2_o = s2_q;

endmodule

// File: rtl/taus_urng_sched.sv
// rtl/taus_urng_sched.sv - seeds, warms up and round-robin shares one Tausworthe URNG
module taus_urng_sched
  import taus_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WARMUP = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            seed_load,
  input  logic [31:0]     urng_seed1,
  input  logic [31:0]     urng_seed2,
  input  logic [31:0]     urng_seed3,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            rnd_valid,
  output logic [31:0]     rnd_data,
  output logic [IDW-1:0]  rnd_id,
  output logic            ready,
  output logic            seed_err
);

  localparam logic [7:0] WARM_INIT = 8'(WARMUP);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            err_q, err_d;
  logic            valid_q, valid_d;
  logic [31:0]     data_q, data_d;
  logic [IDW-1:0]  id_q, id_d;

  logic            core_load, core_adv, fire;
  logic [31:0]     core_out;
  logic [31:0]     core_s0, core_s1, core_s2;
  logic [95:0]     unused_core_state;

  logic [NREQ-1:0] scan;
  logic [IDW:0]    off, sum;
  logic            found;
  logic [IDW-1:0]  sel;

  taus_core u_core (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (core_load),
    .adv_i      (core_adv),
    .seed1_i    (urng_seed1),
    .seed2_i    (urng_seed2),
    .seed3_i    (urng_seed3),
    .s0_o       (core_s0),
    .s1_o       (core_s1),
    .s2_o       (core_s2),
    .out_next_o (core_out)
  );

  assign unused_core_state = {core_s0, core_s1, core_s2};

  // Round-robin search: rotate req so the pointer sits at bit 0, take the first set bit.
  always_comb begin
    scan  = NREQ'({req, req} >> ptr_q);
    off   = '0;
    sum   = '0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && scan[0]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + off;
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        sel   = sum[IDW-1:0];
      end
      scan = scan >> 1;
      off  = off + (IDW+1)'(1);
    end
  end

  // Sequencing: seed_load preempts everything; WARM burns steps; RUN grants.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    err_d     = err_q;
    core_load = 1'b0;
    core_adv  = 1'b0;
    fire      = 1'b0;
    gnt       = '0;
    if (seed_load) begin
      if (seeds_legal(urng_seed1, urng_seed2, urng_seed3)) begin
        core_load = 1'b1;
        err_d     = 1'b0;
        cnt_d     = WARM_INIT;
        state_d   = (WARMUP == 0) ? RUN : WARM;
      end else begin
        err_d   = 1'b1;
        state_d = UNSEEDED;
      end
    end else begin
      unique case (state_q)
        WARM: begin
          core_adv = 1'b1;
          cnt_d    = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) state_d = RUN;
        end
        RUN: begin
          if (found) begin
            fire     = 1'b1;
            gnt      = NREQ'(1) << sel;
            core_adv = 1'b1;
            ptr_d    = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Delivered value is captured on the grant edge so it appears one cycle later.
  always_comb begin
    valid_d = fire;
    data_d  = fire ? core_out : data_q;
    id_d    = fire ? sel : id_q;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= UNSEEDED;
      cnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign rnd_valid = valid_q;
  assign rnd_data  = data_q;
  assign rnd_id    = id_q;
  assign ready     = (state_q == RUN);
  assign seed_err  = err_q;

endmodule

// File: tb/tb_taus_urng_sched.sv
// tb/tb_taus_urng_sched.sv - directed table-driven bench for taus_urng_sched
module tb_taus_urng_sched;

  logic        clk = 1'b0;
  logic        reset, seed_load;
  logic [31:0] sd1, sd2, sd3;
  logic [3:0]  req, req0;

  logic [3:0]  gnt, gnt0;
  logic        rnd_valid, rnd_valid0;
  logic [31:0] rnd_data, rnd_data0;
  logic [1:0]  rnd_id, rnd_id0;
  logic        ready, ready0;
  logic        seed_err, seed_err0;

  int checks = 0;
  int failures = 0;

  logic [31:0] m0, m1, m2, exp_v;

  typedef struct packed {
    logic [3:0] rq;
    logic [3:0] g;
    logic       v;
    logic [1:0] id;
  } vec_t;
  vec_t vecs [13];

  always #5 clk = ~clk;

  taus_urng_sched #(.NREQ(4), .WARMUP(8)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load),
    .urng_seed1(sd1), .urng_seed2(sd2), .urng_seed3(sd3),
    .req(req), .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .rnd_id(rnd_id), .ready(ready), .seed_err(seed_err)
  );

  taus_urng_sched #(.NREQ(4), .WARMUP(0)) dut0 (
    .clk(clk), .reset(reset), .seed_load(seed_load),
    .urng_seed1(sd1), .urng_seed2(sd2), .urng_seed3(sd3),
    .req(req0), .gnt(gnt0), .rnd_valid(rnd_valid0), .rnd_data(rnd_data0),
    .rnd_id(rnd_id0), .ready(ready0), .seed_err(seed_err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    m0 = a;
    m1 = b;
    m2 = c;
  endtask

  task automatic model_step(output logic [31:0] o);
    logic [31:0] b;
    b  = ((m0 << 13) ^ m0) >> 19;
    m0 = ((m0 & 32'hFFFFFFFE) << 12) ^ b;
    b  = ((m1 << 2) ^ m1) >> 25;
    m1 = ((m1 & 32'hFFFFFFF8) << 4) ^ b;
    b  = ((m2 << 3) ^ m2) >> 11;
    m2 = ((m2 & 32'hFFFFFFF0) << 17) ^ b;
    o  = m0 ^ m1 ^ m2;
  endtask

  task automatic legal_load_and_warm(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                     input string tag);
    logic [31:0] dummy;
    sd1 = a; sd2 = b; sd3 = c;
    seed_load = 1'b1;
    #1;
    chk({tag, "_gnt_on_load"}, 32'(gnt), 32'd0);
    tick();
    seed_load = 1'b0;
    model_load(a, b, c);
    chk({tag, "_valid_after_load"}, 32'(rnd_valid), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk({tag, "_warm_gnt"}, 32'(gnt), 32'd0);
      chk({tag, "_warm_ready"}, 32'(ready), 32'd0);
      tick();
      model_step(dummy);
    end
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{4'b1111, 4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{4'b1111, 4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{4'b1111, 4'b0001, 1'b1, 2'd0};
    vecs[5]  = '{4'b1111, 4'b0010, 1'b1, 2'd1};
    vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[7]  = '{4'b1010, 4'b1000, 1'b1, 2'd3};
    vecs[8]  = '{4'b1010, 4'b0010, 1'b1, 2'd1};
    vecs[9]  = '{4'b0011, 4'b0001, 1'b1, 2'd0};
    vecs[10] = '{4'b1001, 4'b1000, 1'b1, 2'd3};
    vecs[11] = '{4'b1000, 4'b1000, 1'b1, 2'd3};
    vecs[12] = '{4'b0001, 4'b0001, 1'b1, 2'd0};

    reset = 1'b0; seed_load = 1'b0; req = '0; req0 = '0;
    sd1 = '0; sd2 = '0; sd3 = '0;
    m0 = '0; m1 = '0; m2 = '0; exp_v = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(rnd_valid), 32'd0);
    chk("rst_data", rnd_data, 32'd0);
    chk("rst_id", 32'(rnd_id), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_seed_err", 32'(seed_err), 32'd0);
    reset = 1'b1;

    // Minimum legal seeds on the WARMUP=0 instance: known first value.
    sd1 = 32'd2; sd2 = 32'd8; sd3 = 32'd16;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("w0_ready", 32'(ready0), 32'd1);
    req0 = 4'b0001;
    #1;
    chk("w0_gnt", 32'(gnt0), 32'd1);
    tick();
    req0 = 4'b0000;
    chk("w0_valid", 32'(rnd_valid0), 32'd1);
    chk("w0_data", rnd_data0, 32'h00202080);
    chk("w0_id", 32'(rnd_id0), 32'd0);

    // Full warm-up with requests pending, then the round-robin table.
    req = 4'b1111;
    legal_load_and_warm(32'h12345678, 32'h9abcdef0, 32'h0fedcba9, "warmA");
    for (int i = 0; i < 13; i++) begin
      req = vecs[i].rq;
      #1;
      chk("rr_gnt", 32'(gnt), 32'(vecs[i].g));
      tick();
      chk("rr_valid", 32'(rnd_valid), 32'(vecs[i].v));
      if (vecs[i].v) begin
        model_step(exp_v);
        chk("rr_id", 32'(rnd_id), 32'(vecs[i].id));
        chk("rr_data", rnd_data, exp_v);
      end
    end

    // Illegal seeds: seed2=7, then seed1=1 and seed3=15 boundaries.
    for (int j = 0; j < 2; j++) begin
      req = 4'b1111;
      if (j == 0) begin sd1 = 32'd5; sd2 = 32'd7; sd3 = 32'd100; end
      else begin sd1 = 32'd1; sd2 = 32'd8; sd3 = 32'd15; end
      seed_load = 1'b1;
      #1;
      chk("bad_gnt_on_load", 32'(gnt), 32'd0);
      tick();
      seed_load = 1'b0;
      chk("bad_valid", 32'(rnd_valid), 32'd0);
      chk("bad_seed_err", 32'(seed_err), 32'd1);
      chk("bad_ready", 32'(ready), 32'd0);
      #1;
      chk("bad_gnt_idle", 32'(gnt), 32'd0);
      tick();
      chk("bad_valid_idle", 32'(rnd_valid), 32'd0);
    end

    req = 4'b0000;
    legal_load_and_warm(32'hdeadbeef, 32'd8, 32'd16, "warmB");
    chk("seed_err_cleared", 32'(seed_err), 32'd0);

    // One delivery, then a seed_load mid-stream with the request still held.
    req = 4'b0100;
    #1;
    chk("mid_gnt", 32'(gnt), 32'b0100);
    tick();
    model_step(exp_v);
    chk("mid_valid", 32'(rnd_valid), 32'd1);
    chk("mid_data", rnd_data, exp_v);
    chk("mid_id", 32'(rnd_id), 32'd2);
    legal_load_and_warm(32'hcafef00d, 32'h0badf00d, 32'h13579bdf, "warmC");
    #1;
    chk("restart_gnt", 32'(gnt), 32'b0100);
    tick();
    model_step(exp_v);
    chk("restart_valid", 32'(rnd_valid), 32'd1);
    chk("restart_data", rnd_data, exp_v);
    chk("restart_id", 32'(rnd_id), 32'd2);

    // Reset during RUN with a request pending; pointer must come back at 0.
    reset = 1'b0;
    tick();
    chk("rr_rst_gnt", 32'(gnt), 32'd0);
    chk("rr_rst_valid", 32'(rnd_valid), 32'd0);
    chk("rr_rst_data", rnd_data, 32'd0);
    chk("rr_rst_id", 32'(rnd_id), 32'd0);
    chk("rr_rst_ready", 32'(ready), 32'd0);
    chk("rr_rst_seed_err", 32'(seed_err), 32'd0);
    reset = 1'b1;
    req = 4'b1111;
    legal_load_and_warm(32'h00000003, 32'h00000009, 32'h00000011, "warmD");
    #1;
    chk("ptr_after_rst_gnt", 32'(gnt), 32'b0001);
    tick();
    model_step(exp_v);
    chk("ptr_after_rst_data", rnd_data, exp_v);
    chk("ptr_after_rst_id", 32'(rnd_id), 32'd0);
    req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
